// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption engine: one 128-bit block per operation, RPC rounds per clock
// through a shared round datapath, with round keys fetched from an external key store.
module aes_cipher_iter #(
    parameter int RPC     = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic         eph1,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [1:0]   in_keylen,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data0,
    input  logic [127:0] rk_data1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [3:0] RPC_W = 4'(RPC);

    fsm_t         state_q, state_d;
    logic [127:0] blk;
    logic [3:0]   rnd;
    logic [3:0]   nr;
    logic [3:0]   nr_sel;
    logic [127:0] rnd_res;
    logic         load;
    logic         finish;
    logic         last_step;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] inv;
        t = a;
        for (int i = 0; i < 6; i++) begin
            t = gmul(gmul(t, t), a);
        end
        inv = gmul(t, t);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   mc [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(s[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                sr[4*c+rr] = sb[4*((c+rr)%4)+rr];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) begin
                mc[4*c]   = a0;
                mc[4*c+1] = a1;
                mc[4*c+2] = a2;
                mc[4*c+3] = a3;
            end else begin
                mc[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                mc[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                mc[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                mc[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = mc[i];
        end
        return r ^ k;
    endfunction

    generate
        if (RPC == 2) begin : g_two
            logic [127:0] rnd_a;
            assign rnd_a   = aes_round(blk, rk_data0, rnd == nr);
            assign rnd_res = aes_round(rnd_a, rk_data1, (rnd + 4'd1) == nr);
        end else begin : g_one
            logic unused_rk1;
            assign unused_rk1 = ^rk_data1;
            assign rnd_res    = aes_round(blk, rk_data0, rnd == nr);
        end
    endgenerate

    // Reserved keylen 11 runs as AES-128.
    always_comb begin
        case (in_keylen)
            2'b01:   nr_sel = 4'd12;
            2'b10:   nr_sel = 4'd14;
            default: nr_sel = 4'd10;
        endcase
    end

    assign last_step = (rnd + RPC_W - 4'd1) == nr;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = 4'd0;
        load      = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                rk_idx = rnd;
                if (last_step) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge eph1) begin
        if (reset) begin
            state_q <= IDLE;
            blk     <= '0;
            rnd     <= 4'd0;
            nr      <= 4'd0;
        end else begin
            state_q <= state_d;
            if (load) begin
                blk <= in_data ^ rk_data0;
                nr  <= nr_sel;
                rnd <= 4'd1;
            end else if (state_q == RUN) begin
                blk <= rnd_res;
                rnd <= finish ? 4'd0 : rnd + RPC_W;
            end
        end
    end

    generate
        if (OUT_REG) begin : g_oreg
            logic [127:0] out_q;
            always_ff @(posedge eph1) begin
                if (reset) out_q <= '0;
                else if (finish) out_q <= rnd_res;
            end
            assign out_data = out_q;
        end else begin : g_oalias
            assign out_data = blk;
        end
    endgenerate

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: FIPS-197 vectors, scoreboard of expected ciphertext/latency,
// backpressure hold and reset during a run.
module tb_aes_cipher_iter;

    localparam int RPC = 1;
    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

    logic         eph1 = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [1:0]   in_keylen = 2'b00;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data0;
    logic [127:0] rk_data1;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    aes_cipher_iter #(.RPC(RPC), .OUT_REG(1'b1)) dut (
        .eph1(eph1), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_keylen(in_keylen), .rk_idx(rk_idx),
        .rk_data0(rk_data0), .rk_data1(rk_data1), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 eph1 = ~eph1;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk_tab [16];

    assign rk_data0 = rk_tab[rk_idx];
    assign rk_data1 = rk_tab[rk_idx + 4'd1];

    typedef struct {
        logic [1:0]   keylen;
        int           nk;
        int           nr;
        logic [127:0] ct;
    } vec_t;

    typedef struct {
        logic [127:0] ct;
        int           lat;
    } exp_t;

    vec_t vecs [4];
    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Table built with the multiplicative-generator walk rather than an inverse computation.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic expand_key(input int nk);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = KEY[255-32*i -: 32];
        for (int i = nk; i < 60; i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                temp = subw(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r < 15; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk_tab[15] = '0;
    endtask

    task automatic start_block(input vec_t v);
        expand_key(v.nk);
        @(negedge eph1);
        in_data   = PT;
        in_keylen = v.keylen;
        in_valid  = 1'b1;
        chk("idle_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge eph1);
        sb.push_back('{ct: v.ct, lat: v.nr / RPC});
        #1;
        // Junk on the input side while running must be ignored.
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        in_keylen = ~v.keylen;
    endtask

    task automatic wait_result(input string name);
        int   c;
        int   rk_bad;
        exp_t e;
        c = 0;
        rk_bad = 0;
        @(negedge eph1);
        while (!out_valid && c < 100) begin
            if (rk_idx !== 4'(c + 1) || in_ready !== 1'b0 || busy !== 1'b1) rk_bad++;
            c++;
            @(negedge eph1);
        end
        in_valid = 1'b0;
        if (c >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: out_valid never rose within %0d cycles", name, c);
        end
        chk({name, "_run_seq"}, 128'(rk_bad), 128'd0);
        chk({name, "_rk_done"}, {124'd0, rk_idx}, 128'd0);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: result with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_ct"}, out_data, e.ct);
            chk({name, "_lat"}, 128'(c), 128'(e.lat));
        end
    endtask

    task automatic finish_block(input string name);
        logic [127:0] held;
        held = out_data;
        out_ready = 1'b1;
        @(posedge eph1);
        #1;
        out_ready = 1'b0;
        @(negedge eph1);
        chk({name, "_ov_drop"}, {127'd0, out_valid}, 128'd0);
        chk({name, "_idle_ready"}, {127'd0, in_ready}, 128'd1);
        chk({name, "_out_hold"}, out_data, held);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        logic [127:0] snap;
        vecs[0] = '{keylen: 2'b00, nk: 4, nr: 10, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{keylen: 2'b01, nk: 6, nr: 12, ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
        vecs[2] = '{keylen: 2'b10, nk: 8, nr: 14, ct: 128'h8ea2b7ca516745bfeafc49904b496089};
        vecs[3] = '{keylen: 2'b11, nk: 4, nr: 10, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        build_sbox();
        expand_key(4);

        repeat (3) @(posedge eph1);
        @(negedge eph1);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_rk_idx", {124'd0, rk_idx}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            start_block(vecs[i]);
            wait_result($sformatf("vec%0d", i));
            finish_block($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold for 20 cycles with out_ready low.
        start_block(vecs[0]);
        wait_result("bp");
        snap = out_data;
        bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge eph1);
            if (out_valid !== 1'b1 || out_data !== snap || in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        chk("bp_stable", 128'(bad), 128'd0);
        finish_block("bp");

        // Reset during the 4th RUN cycle of an AES-256 block.
        start_block(vecs[2]);
        repeat (3) @(posedge eph1);
        @(negedge eph1);
        chk("mid_rk_idx", {124'd0, rk_idx}, 128'd4);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge eph1);
        @(negedge eph1);
        chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("mid_rst_rk_idx", {124'd0, rk_idx}, 128'd0);
        chk("mid_rst_busy", {127'd0, busy}, 128'd0);
        chk("mid_rst_out_data", out_data, 128'd0);
        reset = 1'b0;
        sb.delete();
        start_block(vecs[0]);
        wait_result("post_rst");
        finish_block("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
